// File: rtl/step_trig.sv
// Step-trigger stage: 8-step x 4-voice pattern store that fires fixed-length trigger pulses on step entry.
// Optional build macro STEP_TRIG_ACCENT_EN widens the pattern to 5 bits and adds the registered accent output.
module step_trig #(
  parameter int GATE_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sel,
  input  logic [2:0] tick,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
`ifdef STEP_TRIG_ACCENT_EN
  input  logic [4:0] wr_data,
  output logic       accent,
`else
  input  logic [3:0] wr_data,
`endif
  output logic [3:0] trig,
  output logic       step_err
);

`ifdef STEP_TRIG_ACCENT_EN
  localparam int PW = 5;
`else
  localparam int PW = 4;
`endif

  localparam logic [2:0] GATE_LOAD = 3'(GATE_TICKS);

  generate
    if (GATE_TICKS < 1 || GATE_TICKS > 7) begin : g_bad_gate
      $error("step_trig: GATE_TICKS must be in 1..7");
    end
  endgenerate

  logic [PW-1:0] pat_reg [8];
  logic [7:0]    sel_d_reg;
  logic [2:0]    tick_d_reg;
  logic [3:0]    trig_reg;
  logic [3:0]    trig_next;
  logic          step_err_reg;

  logic [2:0]    step_idx;
  logic [PW-1:0] step_pat;
  logic          sel_onehot;
  logic          sel_changed;
  logic          step_entry;
  logic          sel_bad;
  logic          tick_adv;

  always_comb begin
    step_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) step_idx = 3'(i);
    end
  end

  assign sel_onehot  = (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
  assign sel_changed = (sel != sel_d_reg);
  assign step_entry  = sel_changed && sel_onehot;
  assign sel_bad     = sel_changed && (sel != 8'd0) && !sel_onehot;
  assign tick_adv    = (tick != tick_d_reg);
  // Read comes from the pre-edge register contents, so a same-cycle write never affects this entry.
  assign step_pat    = pat_reg[step_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) pat_reg[i] <= '0;
    end else if (wr_en) begin
      pat_reg[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_d_reg    <= 8'd0;
      tick_d_reg   <= 3'd0;
      step_err_reg <= 1'b0;
      trig_reg     <= 4'd0;
    end else begin
      sel_d_reg  <= sel;
      tick_d_reg <= tick;
      trig_reg   <= trig_next;
      if (sel_bad) step_err_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_voice
      logic [2:0] cnt_reg;
      logic [2:0] cnt_next;

      // Reload takes priority over a coincident tick advance.
      always_comb begin
        cnt_next = cnt_reg;
        if (step_entry && step_pat[gi]) begin
          cnt_next = GATE_LOAD;
        end else if (tick_adv && (cnt_reg != 3'd0)) begin
          cnt_next = cnt_reg - 3'd1;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= 3'd0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign trig_next[gi] = (cnt_next != 3'd0);
    end
  endgenerate

  assign trig     = trig_reg;
  assign step_err = step_err_reg;

`ifdef STEP_TRIG_ACCENT_EN
  logic accent_reg;
  logic accent_next;

  always_comb begin
    accent_next = accent_reg;
    if (step_entry && step_pat[4] && (step_pat[3:0] != 4'd0)) begin
      accent_next = 1'b1;
    end else if (trig_next == 4'd0) begin
      accent_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      accent_reg <= 1'b0;
    end else begin
      accent_reg <= accent_next;
    end
  end

  assign accent = accent_reg;
`endif

endmodule

// File: tb/tb_step_trig.sv
// Self-checking bench for step_trig: directed scenarios plus randomized traffic against a behavioural model.
module tb_step_trig;

`ifdef STEP_TRIG_ACCENT_EN
  localparam int PW = 5;
`else
  localparam int PW = 4;
`endif
  localparam int GATE = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    sel;
  logic [2:0]    tick;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [PW-1:0] wr_data;
  logic [3:0]    trig;
  logic          step_err;
`ifdef STEP_TRIG_ACCENT_EN
  logic          accent;
`endif

  always #5 clk = ~clk;

  step_trig #(.GATE_TICKS(GATE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (sel),
    .tick     (tick),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
`ifdef STEP_TRIG_ACCENT_EN
    .wr_data  (wr_data),
    .accent   (accent),
`else
    .wr_data  (wr_data),
`endif
    .trig     (trig),
    .step_err (step_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: remaining tick count per voice, pattern array, previous inputs.
  int            rem [4];
  logic [PW-1:0] m_pat [8];
  logic [7:0]    m_sel_d;
  logic [2:0]    m_tick_d;
  bit            m_err;
  bit            m_acc;

  function automatic logic [3:0] exp_trig();
    logic [3:0] t;
    for (int v = 0; v < 4; v++) t[v] = (rem[v] > 0);
    return t;
  endfunction

  task automatic model_update();
    bit onehot;
    bit entry;
    int s;
    if (!rst_n) begin
      for (int v = 0; v < 4; v++) rem[v] = 0;
      for (int i = 0; i < 8; i++) m_pat[i] = '0;
      m_sel_d = 8'd0; m_tick_d = 3'd0; m_err = 0; m_acc = 0;
    end else begin
      onehot = ($countones(sel) == 1);
      entry  = (sel != m_sel_d) && onehot;
      s = 0;
      for (int i = 0; i < 8; i++) if (sel[i]) s = i;
      for (int v = 0; v < 4; v++) begin
        if (entry && m_pat[s][v]) rem[v] = GATE;
        else if (tick != m_tick_d && rem[v] > 0) rem[v] = rem[v] - 1;
      end
`ifdef STEP_TRIG_ACCENT_EN
      if (entry && m_pat[s][4] && m_pat[s][3:0] != 4'd0) m_acc = 1;
      else if (exp_trig() == 4'd0) m_acc = 0;
`endif
      if (sel != m_sel_d && sel != 8'd0 && !onehot) m_err = 1;
      if (wr_en) m_pat[wr_addr] = wr_data;
      m_sel_d  = sel;
      m_tick_d = tick;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("trig", {4'd0, trig}, {4'd0, exp_trig()});
    check("step_err", {7'd0, step_err}, {7'd0, m_err});
`ifdef STEP_TRIG_ACCENT_EN
    check("accent", {7'd0, accent}, {7'd0, m_acc});
`endif
  endtask

  task automatic write_pat(input logic [2:0] a, input logic [PW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sel = 8'd0; tick = 3'd0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = '0;

    // Reset held with sel toggling
    for (int i = 0; i < 3; i++) begin
      sel = 8'h01 << i;
      cycle();
      check("rst_trig", {4'd0, trig}, 8'd0);
      check("rst_err", {7'd0, step_err}, 8'd0);
    end
    rst_n = 1'b1;

    // Full lap on an empty pattern
    for (int i = 0; i < 8; i++) begin
      sel = 8'h01 << ((i + 3) % 8);
      tick = tick + 3'd1;
      cycle();
      check("lap_empty", {4'd0, trig}, 8'd0);
    end

    // Basic fire
    sel = 8'h00;
    write_pat(3'd2, 4'b0101);
    sel = 8'h02; cycle();
    sel = 8'h04; cycle();
    check("basic_fire", {4'd0, trig}, 8'h05);
    tick = tick + 3'd1; cycle();
    check("basic_hold", {4'd0, trig}, 8'h05);
    tick = tick + 3'd1; cycle();
    check("basic_fall", {4'd0, trig}, 8'h00);

    // Retrigger
    write_pat(3'd3, 4'b0001);
    write_pat(3'd4, 4'b0001);
    sel = 8'h08; cycle();
    check("retrig_fire", {4'd0, trig}, 8'h01);
    tick = tick + 3'd1; cycle();
    check("retrig_one_tick", {4'd0, trig}, 8'h01);
    sel = 8'h10; cycle();
    check("retrig_reload", {4'd0, trig}, 8'h01);
    tick = tick + 3'd1; cycle();
    check("retrig_hold", {4'd0, trig}, 8'h01);
    tick = tick + 3'd1; cycle();
    check("retrig_fall", {4'd0, trig}, 8'h00);

    // Write/entry collision
    sel = 8'h20;
    write_pat(3'd5, 4'b1000);
    check("collide_old", {4'd0, trig}, 8'h00);
    sel = 8'h40; cycle();
    sel = 8'h20; cycle();
    check("collide_next_lap", {4'd0, trig}, 8'h08);
    tick = tick + 3'd1; cycle();
    tick = tick + 3'd1; cycle();
    check("collide_fall", {4'd0, trig}, 8'h00);

`ifdef STEP_TRIG_ACCENT_EN
    sel = 8'h01; cycle();
    write_pat(3'd1, 5'b10010);
    sel = 8'h02; cycle();
    check("accent_rise", {7'd0, accent}, 8'h01);
    check("accent_trig", {4'd0, trig}, 8'h02);
    tick = tick + 3'd1; cycle();
    tick = tick + 3'd1; cycle();
    check("accent_fall", {7'd0, accent}, 8'h00);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst_n = ($urandom_range(0, 199) != 0);
      r = $urandom_range(0, 99);
      if (r < 60) begin
        sel = sel;
      end else if (r < 90) begin
        sel = 8'h01 << $urandom_range(0, 7);
      end else if (r < 95) begin
        sel = 8'h00;
      end else if (r < 96) begin
        int a;
        int b;
        a = $urandom_range(0, 7);
        b = (a + $urandom_range(1, 7)) % 8;
        sel = (8'h01 << a) | (8'h01 << b);
      end
      r = $urandom_range(0, 99);
      if (r < 40) tick = tick + 3'd1;
      else if (r < 45) tick = 3'($urandom_range(0, 7));
      wr_en   = ($urandom_range(0, 4) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = PW'($urandom);
      cycle();
    end
    wr_en = 1'b0;

    // Invalid select
    rst_n = 1'b0; sel = 8'h00; cycle();
    rst_n = 1'b1;
    write_pat(3'd0, 4'hF);
    write_pat(3'd1, 4'hF);
    check("zero_sel_no_err", {7'd0, step_err}, 8'h00);
    sel = 8'h03; cycle();
    check("invalid_err", {7'd0, step_err}, 8'h01);
    check("invalid_no_trig", {4'd0, trig}, 8'h00);
    sel = 8'h04; cycle();
    sel = 8'h01; cycle();
    check("valid_after_invalid", {4'd0, trig}, 8'h0F);
    check("err_sticky", {7'd0, step_err}, 8'h01);
    rst_n = 1'b0; cycle();
    check("err_cleared", {7'd0, step_err}, 8'h00);
    check("reset_mid_pulse", {4'd0, trig}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_trig.md
# step_trig

Step-trigger stage placed directly downstream of the step sequencer: it consumes the sequencer's one-hot step select `sel[7:0]` and sub-step phase `tick[2:0]`. It holds an 8-step x 4-voice pattern and fires a fixed-length trigger pulse on each voice whose bit is set for the step just entered. Its outputs drive the voice/drum trigger pins.

## Interface
- `GATE_TICKS`, default 2: trigger length in tick advances; legal range 1..7.
- `clk` in 1: system clock, shared with the sequencer.
- `rst_n` in 1: synchronous, active-low reset.
- `sel` in 8: one-hot step select from the sequencer.
- `tick` in 3: sub-step phase counter from the sequencer.
- `wr_en` in 1: pattern write strobe, one write per cycle.
- `wr_addr` in 3: step index to write.
- `wr_data` in 4: voice bits for that step; bit v enables voice v.
- `trig` out 4: per-voice trigger pulses, registered.
- `step_err` out 1: sticky flag, set when `sel` is non-zero and not one-hot.

## Operation
- Pattern store: 8 x 4-bit registers `pat[0..7]`. A write with `wr_en=1` updates `pat[wr_addr]` at the clock edge.
- Registered copies `sel_d` and `tick_d` are updated every cycle.
- Step entry: `sel != sel_d` and `sel` is exactly one-hot. The step index s is the position of the set bit.
- On step entry, each voice v with `pat[s][v]=1` loads its gate counter with `GATE_TICKS` and asserts `trig[v]`.
- Voices with bit 0 are unaffected, and any running gate continues.
- Tick advance: `tick != tick_d`. Each active voice counter decrements by 1 per tick advance. When the counter reaches 0, `trig[v]` deasserts at that same edge.
- Retrigger: a step entry hitting a voice that is already active reloads its counter to `GATE_TICKS`. `trig[v]` stays high with no low gap.
- Step entry and tick advance in the same cycle: the reload wins, and no decrement is applied to reloaded voices.
- Invalid select: if `sel` changes to a non-zero, non-one-hot value, no triggers fire and `step_err` is set until reset. `sel=0` is ignored without error.
- Write/read collision: a write to step s in the same cycle as entry into step s does not affect that entry. The old `pat[s]` value is used; the new value applies from the next entry.
- Counters are 3 bits. `GATE_TICKS=0` or values above 7 are illegal; an elaboration-time check is required.

## Timing
- Reset values (`rst_n=0` at a clock edge):
  - `trig=0`, `step_err=0`.
  - All `pat` registers 0, all counters 0.
  - `sel_d=0`, `tick_d=0`.
- Reset mid-pulse: trig drops at the reset edge and pending counts are discarded.
- After reset, the first one-hot `sel` counts as a step entry.
- Trigger latency: `sel` changes before edge E; `trig` rises at edge E, i.e. one cycle after the change.
- Pulse width: high until the edge at which the `GATE_TICKS`-th tick advance after the entry is sampled.
- Write latency: a write is visible to a step entry one cycle later.
- `step_err` is set at the edge following the invalid `sel` value.

## Configuration
- `STEP_TRIG_ACCENT_EN`, when defined:
  - Pattern width becomes 5 bits. `wr_data` is 5 bits, and bit 4 is the accent flag.
  - Adds output `accent` (1 bit, reset 0). It is registered, rises with the step-entry triggers when `pat[s][4]=1`, and falls when all `trig` bits are low.
  - Accent is asserted only on entry into a step whose accent bit is set **and** that has at least one voice bit set.
- When not defined: `wr_data` is 4 bits, there is no `accent` port and no accent logic.

## Test plan
- **Reset:** hold `rst_n=0` for 3 cycles with `sel` toggling -> `trig=0`, `step_err=0` throughout; every step then reads back pattern 0 (no triggers on a full sequencer lap).
- **Basic fire:** write `pat[2]=4'b0101`, then step `sel` 0x02 -> 0x04 -> `trig=4'b0101` exactly one cycle after the change. With `GATE_TICKS=2`, trig falls on the edge sampling the second tick advance.
- **Retrigger:** `pat[3]=pat[4]=4'b0001`, with the step changing from 3 to 4 after only 1 tick advance -> `trig[0]` stays continuously high and the counter reloads to 2.
- **Collision:** write `pat[5]=4'b1000` in the same cycle `sel` becomes 0x20 while the old `pat[5]=0` -> no trigger. On the next lap, entering step 5 -> `trig[3]` pulses.
- **Invalid select:** `sel=0x03` -> no triggers and `step_err=1`, held through later valid steps until reset. `sel=0x00` -> no error.
- **Accent (with `STEP_TRIG_ACCENT_EN`):** write `wr_data=5'b10010` to step 1 and enter step 1 -> `accent` and `trig[1]` rise together and fall together.
